// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, two clocked write ports,
// optional hard-zero R0, optional write-to-read forwarding, and a sequential clear engine.
module reg_file_mp #(
    parameter int DW      = 8,
    parameter int PW      = 4,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrA_en,
    input  logic [PW-1:0] wrA_addr,
    input  logic [DW-1:0] wrA_dat,
    input  logic          wrB_en,
    input  logic [PW-1:0] wrB_addr,
    input  logic [DW-1:0] wrB_dat,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam int DEPTH = 1 << PW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic          clearing;

    logic [DW-1:0] core [DEPTH];
    logic [DW-1:0] nxt  [DEPTH];

    assign clearing = (state == ST_CLEAR);
    assign clr_busy = clearing;
    assign clr_done = (state == ST_DONE);

    // Post-edge value of every entry: clear of that entry > port B > port A > hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = core[i];
            if (rst_n) begin
                if (wrA_en && wrA_addr == PW'(i))
                    nxt[i] = wrA_dat;
                if (wrB_en && wrB_addr == PW'(i))
                    nxt[i] = wrB_dat;
                if (clearing && ptr == PW'(i))
                    nxt[i] = '0;
            end
            if (ZERO_R0 != 0 && i == 0)
                nxt[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                core[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                core[i] <= nxt[i];
        end
    end

    // Forwarding reads see the resolved post-edge value; otherwise the stored one.
    always_comb begin
        datA_out = (BYPASS != 0) ? nxt[rd_addrA] : core[rd_addrA];
        datB_out = (BYPASS != 0) ? nxt[rd_addrB] : core[rd_addrB];
        if (ZERO_R0 != 0 && rd_addrA == '0)
            datA_out = '0;
        if (ZERO_R0 != 0 && rd_addrB == '0)
            datB_out = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    // ptr wraps to 0 on the same edge that leaves CLEAR
                    ptr <= ptr + PW'(1);
                    if (ptr == PW'(DEPTH - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
